// File: rtl/stopwatch_ctrl.sv
// Stopwatch run-control: synchronises the 1 kHz timebase, runs IDLE/RUN/LAP/PAUSE,
// keeps the MM:SS.cc BCD count and a lap snapshot, and drives the registered display value.
module stopwatch_ctrl #(
    parameter int SYNC_STAGES  = 2,
    parameter int TICKS_PER_CS = 10
) (
    input  logic        clk_100mhz,
    input  logic        rst_n,
    input  logic        clk_1ms_in,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    input  logic        btn_clear,
    output logic [1:0]  state,
    output logic        running,
    output logic [23:0] disp_bcd,
    output logic        overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10,
        S_LAP   = 2'b11
    } state_e;

    localparam int PW = (TICKS_PER_CS > 1) ? $clog2(TICKS_PER_CS) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(TICKS_PER_CS - 1);

    // Digit order low to high: cs1, cs10, sec1, sec10, min1, min10; bit 24 flags the full wrap.
    function automatic logic [24:0] bcd_inc(input logic [23:0] t);
        logic [23:0] r;
        logic        c;
        logic [3:0]  lim;
        r = t;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lim = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            if (c) begin
                if (r[i*4 +: 4] == lim) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    state_e                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     prev_q;
    logic                     tick_q;
    logic [PW-1:0]            presc_q, presc_d;
    logic [23:0]              time_q, time_d;
    logic [23:0]              lap_q, lap_d;
    logic [23:0]              disp_q, disp_d;
    logic                     ovf_q, ovf_d;
    logic [24:0]              inc_w;
    logic                     do_clear, do_ss, do_lap;

    assign running  = (state_q == S_RUN) || (state_q == S_LAP);
    assign state    = state_q;
    assign disp_bcd = disp_q;
    assign overflow = ovf_q;
    assign inc_w    = bcd_inc(time_q);

    assign do_clear = btn_clear;
    assign do_ss    = btn_start_stop & ~btn_clear;
    assign do_lap   = btn_lap & ~btn_clear & ~btn_start_stop;
    assign disp_d   = (state_q == S_LAP) ? lap_q : time_q;

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        presc_d = presc_q;
        lap_d   = lap_q;
        ovf_d   = ovf_q;
        // Counting is gated by the state before any button takes effect this cycle.
        if (tick_q && running) begin
            if (presc_q == PRE_TC) begin
                presc_d = '0;
                time_d  = inc_w[23:0];
                if (inc_w[24]) ovf_d = 1'b1;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
        case (state_q)
            S_IDLE: begin
                if (do_clear) begin
                    time_d  = '0;
                    presc_d = '0;
                    lap_d   = '0;
                    ovf_d   = 1'b0;
                end else if (do_ss) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (do_ss) begin
                    state_d = S_PAUSE;
                end else if (do_lap) begin
                    state_d = S_LAP;
                    lap_d   = time_q;
                end
            end
            S_LAP: begin
                if (do_ss)       state_d = S_PAUSE;
                else if (do_lap) state_d = S_RUN;
            end
            S_PAUSE: begin
                if (do_clear) begin
                    state_d = S_IDLE;
                    time_d  = '0;
                    presc_d = '0;
                    lap_d   = '0;
                    ovf_d   = 1'b0;
                end else if (do_ss) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sync_q  <= '0;
            prev_q  <= 1'b0;
            tick_q  <= 1'b0;
            presc_q <= '0;
            time_q  <= '0;
            lap_q   <= '0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], clk_1ms_in};
            prev_q  <= sync_q[SYNC_STAGES-1];
            tick_q  <= sync_q[SYNC_STAGES-1] & ~prev_q;
            presc_q <= presc_d;
            time_q  <= time_d;
            lap_q   <= lap_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed vector table, corner sequences and random stimulus,
// all checked every cycle against a centisecond-integer reference model.
module tb_stopwatch_ctrl;

    localparam int S = 2;
    localparam int T = 1;
    localparam int IDLE = 0, RUN = 1, PAUSE = 2, LAP = 3;

    logic        clk_100mhz = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_1ms_in = 1'b0;
    logic        btn_start_stop = 1'b0;
    logic        btn_lap = 1'b0;
    logic        btn_clear = 1'b0;
    logic [1:0]  state;
    logic        running;
    logic [23:0] disp_bcd;
    logic        overflow;

    int n_tests = 0;
    int n_fail  = 0;

    stopwatch_ctrl #(.SYNC_STAGES(S), .TICKS_PER_CS(T)) dut (
        .clk_100mhz     (clk_100mhz),
        .rst_n          (rst_n),
        .clk_1ms_in     (clk_1ms_in),
        .btn_start_stop (btn_start_stop),
        .btn_lap        (btn_lap),
        .btn_clear      (btn_clear),
        .state          (state),
        .running        (running),
        .disp_bcd       (disp_bcd),
        .overflow       (overflow)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    // Reference model: time and lap held as plain centisecond counts.
    int m_state, m_cs, m_pre, m_lap, m_disp;
    bit m_ovf;
    bit hist [S+3];

    typedef struct {
        bit          ss;
        bit          lp;
        bit          cl;
        int          nedge;
        logic [23:0] disp;
        logic [1:0]  st;
        bit          ovf;
    } vec_t;

    vec_t vt [21];

    function automatic logic [23:0] to_bcd(input int cs);
        int mn, sc, c;
        mn = cs / 6000;
        sc = (cs / 100) % 60;
        c  = cs % 100;
        return {4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = IDLE; m_cs = 0; m_pre = 0; m_lap = 0; m_disp = 0; m_ovf = 1'b0;
        for (int i = 0; i < S + 3; i++) hist[i] = 1'b0;
    endtask

    task automatic model_step(input bit ss, input bit lp, input bit cl, input bit in1);
        int old_cs;
        bit tick, run;
        for (int i = S + 2; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = in1;
        tick   = hist[S+1] && !hist[S+2];
        run    = (m_state == RUN) || (m_state == LAP);
        old_cs = m_cs;
        m_disp = (m_state == LAP) ? m_lap : m_cs;
        if (tick && run) begin
            if (m_pre == T - 1) begin
                m_pre = 0;
                if (m_cs == 359999) begin m_cs = 0; m_ovf = 1'b1; end
                else m_cs = m_cs + 1;
            end else begin
                m_pre = m_pre + 1;
            end
        end
        if (cl) begin
            if (m_state == IDLE || m_state == PAUSE) begin
                m_state = IDLE; m_cs = 0; m_pre = 0; m_lap = 0; m_ovf = 1'b0;
            end
        end else if (ss) begin
            case (m_state)
                IDLE:    m_state = RUN;
                RUN:     m_state = PAUSE;
                LAP:     m_state = PAUSE;
                default: m_state = RUN;
            endcase
        end else if (lp) begin
            if (m_state == RUN) begin m_state = LAP; m_lap = old_cs; end
            else if (m_state == LAP) m_state = RUN;
        end
    endtask

    task automatic cyc(input bit ss, input bit lp, input bit cl, input bit in1);
        btn_start_stop = ss; btn_lap = lp; btn_clear = cl; clk_1ms_in = in1;
        @(posedge clk_100mhz);
        model_step(ss, lp, cl, in1);
        #1;
        chk("state",    32'(state),    32'(m_state));
        chk("running",  32'(running),  32'((m_state == RUN) || (m_state == LAP)));
        chk("disp_bcd", 32'(disp_bcd), 32'(to_bcd(m_disp)));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        btn_start_stop = 1'b0; btn_lap = 1'b0; btn_clear = 1'b0;
    endtask

    task automatic edges(input int n);
        for (int k = 0; k < n; k++) begin
            repeat (4) cyc(0, 0, 0, 1);
            repeat (4) cyc(0, 0, 0, 0);
        end
    endtask

    task automatic chk_out(input string nm, input logic [23:0] d, input logic [1:0] st, input bit ov);
        chk({nm, "_disp"},  32'(disp_bcd), 32'(d));
        chk({nm, "_state"}, 32'(state),    32'(st));
        chk({nm, "_ovf"},   32'(overflow), 32'(ov));
    endtask

    initial begin
        vt = '{
            '{1'b0, 1'b0, 1'b0,   5, 24'h000000, 2'b00, 1'b0},
            '{1'b1, 1'b0, 1'b0, 123, 24'h000123, 2'b01, 1'b0},
            '{1'b1, 1'b0, 1'b0,   0, 24'h000123, 2'b10, 1'b0},
            '{1'b0, 1'b0, 1'b1,   0, 24'h000000, 2'b00, 1'b0},
            '{1'b1, 1'b0, 1'b0,  50, 24'h000050, 2'b01, 1'b0},
            '{1'b0, 1'b1, 1'b0,   0, 24'h000050, 2'b11, 1'b0},
            '{1'b0, 1'b0, 1'b0,  30, 24'h000050, 2'b11, 1'b0},
            '{1'b0, 1'b1, 1'b0,   0, 24'h000080, 2'b01, 1'b0},
            '{1'b1, 1'b0, 1'b0,   0, 24'h000080, 2'b10, 1'b0},
            '{1'b0, 1'b0, 1'b1,   0, 24'h000000, 2'b00, 1'b0},
            '{1'b1, 1'b0, 1'b0,   7, 24'h000007, 2'b01, 1'b0},
            '{1'b1, 1'b0, 1'b0,   4, 24'h000007, 2'b10, 1'b0},
            '{1'b1, 1'b0, 1'b0,   3, 24'h000010, 2'b01, 1'b0},
            '{1'b1, 1'b0, 1'b0,   0, 24'h000010, 2'b10, 1'b0},
            '{1'b0, 1'b0, 1'b1,   0, 24'h000000, 2'b00, 1'b0},
            '{1'b0, 1'b1, 1'b0,   2, 24'h000000, 2'b00, 1'b0},
            '{1'b1, 1'b0, 1'b0,   2, 24'h000002, 2'b01, 1'b0},
            '{1'b0, 1'b0, 1'b1,   1, 24'h000003, 2'b01, 1'b0},
            '{1'b1, 1'b0, 1'b0,   0, 24'h000003, 2'b10, 1'b0},
            '{1'b0, 1'b1, 1'b0,   0, 24'h000003, 2'b10, 1'b0},
            '{1'b0, 1'b0, 1'b1,   0, 24'h000000, 2'b00, 1'b0}
        };

        model_reset();
        repeat (3) @(posedge clk_100mhz);
        #1;
        chk_out("reset", 24'h000000, 2'b00, 1'b0);
        chk("reset_running", 32'(running), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            cyc(vt[i].ss, vt[i].lp, vt[i].cl, 1'b0);
            edges(vt[i].nedge);
            repeat (6) cyc(0, 0, 0, 0);
            chk_out($sformatf("vec%0d", i), vt[i].disp, vt[i].st, vt[i].ovf);
        end

        // Tick latency: count visible on disp_bcd at the 5th edge after the input rises.
        cyc(1, 0, 0, 0);
        repeat (4) cyc(0, 0, 0, 1);
        chk("latency_before", 32'(disp_bcd), 32'h000000);
        cyc(0, 0, 0, 1);
        chk("latency_after", 32'(disp_bcd), 32'h000001);
        repeat (6) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);

        // Tick coinciding with start_stop: counted in RUN, dropped in PAUSE.
        cyc(1, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        repeat (6) cyc(0, 0, 0, 0);
        chk_out("tick_ss_run", 24'h000001, 2'b10, 1'b0);
        repeat (3) cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 1);
        repeat (6) cyc(0, 0, 0, 0);
        chk_out("tick_ss_pause", 24'h000001, 2'b01, 1'b0);
        edges(1);
        repeat (6) cyc(0, 0, 0, 0);
        chk_out("resume", 24'h000002, 2'b01, 1'b0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 0);
        chk_out("clr_ss_pause", 24'h000000, 2'b00, 1'b0);

        // Wrap at 59:59.99 from a preloaded time.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        force dut.time_q = 24'h595999;
        m_cs = 359999;
        cyc(0, 0, 0, 0);
        release dut.time_q;
        repeat (2) cyc(0, 0, 0, 0);
        chk_out("preload", 24'h595999, 2'b10, 1'b0);
        cyc(1, 0, 0, 0);
        edges(1);
        repeat (6) cyc(0, 0, 0, 0);
        chk_out("wrap", 24'h000000, 2'b01, 1'b1);
        edges(1);
        repeat (6) cyc(0, 0, 0, 0);
        chk_out("after_wrap", 24'h000001, 2'b01, 1'b1);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 0);
        chk_out("ovf_clear", 24'h000000, 2'b00, 1'b0);

        // Asynchronous reset in the middle of a run.
        cyc(1, 0, 0, 0);
        edges(5);
        repeat (2) cyc(0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk_out("async_rst", 24'h000000, 2'b00, 1'b0);
        chk("async_rst_running", 32'(running), 32'd0);
        repeat (2) @(posedge clk_100mhz);
        #1;
        rst_n = 1'b1;
        model_reset();
        repeat (3) cyc(0, 0, 0, 0);

        // Random buttons and a legal-width timebase waveform.
        begin
            bit lvl;
            int hold;
            lvl  = 1'b0;
            hold = 3;
            for (int c = 0; c < 3000; c++) begin
                if (hold == 0) begin
                    lvl  = ~lvl;
                    hold = $urandom_range(S + 1, 6);
                end
                hold--;
                cyc($urandom_range(0, 15) == 0, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 23) == 0, lvl);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
